// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder: FSM encodings, event payload and
// the repeat-count saturation limit, reusable by any multi-key wrapper.
package key_event_decoder_pkg;

   localparam int unsigned RPT_W = 8;
   localparam logic [RPT_W-1:0] RPT_MAX = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } key_state_e;

   typedef struct packed {
      logic press;
      logic rel;
      logic short_click;
      logic long_press;
      logic rpt;
   } key_evt_t;

   function automatic logic [RPT_W-1:0] rpt_sat_inc(input logic [RPT_W-1:0] v);
      return (v == RPT_MAX) ? v : v + RPT_W'(1);
   endfunction

endpackage

// File: rtl/key_edge_det.sv
// Falling-edge detector for the active-low key level. The delay register resets to 0
// so a key already held through reset never looks like a fresh press.
module key_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic fall_c
);

   logic key_d_q;
   logic key_d_d;

   always_comb begin
      key_d_d = key_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_d_q <= 1'b0;
      else     key_d_q <= key_d_d;
   end

   assign fall_c = key_d_q & ~key_n;

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key level into one-clock press/release/click/long/repeat pulses,
// a held flag and a saturating repeat count.
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int unsigned LONG_TIME   = 50_000_000,
   parameter int unsigned REPEAT_TIME = 10_000_000,
   parameter bit          REPEAT_EN   = 1'b1,
   parameter int unsigned CNT_W       = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_n,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             short_click,
   output logic             long_press,
   output logic             repeat_pulse,
   output logic             held,
   output logic [RPT_W-1:0] rpt_cnt
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

   logic fall_c;

   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   key_evt_t         evt_q, evt_d;
   logic             held_q, held_d;

   key_edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key_n),
      .fall_c (fall_c)
   );

   // Next state; a release always takes priority over threshold or repeat events.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      evt_d     = '0;

      case (state_q)
         ST_IDLE: begin
            if (fall_c) begin
               state_d       = ST_PRESS;
               cnt_d         = '0;
               rpt_cnt_d     = '0;
               evt_d.press   = 1'b1;
            end
         end
         ST_PRESS: begin
            if (key_n) begin
               state_d           = ST_IDLE;
               cnt_d             = '0;
               evt_d.rel         = 1'b1;
               evt_d.short_click = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d          = ST_LONG;
               cnt_d            = '0;
               evt_d.long_press = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LONG: begin
            if (key_n) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               evt_d.rel = 1'b1;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d = '0;
               if (REPEAT_EN) begin
                  evt_d.rpt = 1'b1;
                  rpt_cnt_d = rpt_sat_inc(rpt_cnt_q);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      held_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rpt_cnt_q <= '0;
         evt_q     <= '0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rpt_cnt_q <= rpt_cnt_d;
         evt_q     <= evt_d;
         held_q    <= held_d;
      end
   end

   assign press_pulse   = evt_q.press;
   assign release_pulse = evt_q.rel;
   assign short_click   = evt_q.short_click;
   assign long_press    = evt_q.long_press;
   assign repeat_pulse  = evt_q.rpt;
   assign held          = held_q;
   assign rpt_cnt       = rpt_cnt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: three instances cover the default timing,
// REPEAT_TIME=1 saturation and REPEAT_EN=0.
module tb_key_event_decoder;

   logic clk = 1'b0;
   logic rst;
   logic key_a, key_b, key_c;

   logic a_press, a_rel, a_short, a_long, a_rpt, a_held;
   logic b_press, b_rel, b_short, b_long, b_rpt, b_held;
   logic c_press, c_rel, c_short, c_long, c_rpt, c_held;
   logic [7:0] a_cnt, b_cnt, c_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_event_decoder #(.LONG_TIME(10), .REPEAT_TIME(4), .REPEAT_EN(1'b1), .CNT_W(26)) dut_a (
      .clk(clk), .rst(rst), .key_n(key_a),
      .press_pulse(a_press), .release_pulse(a_rel), .short_click(a_short),
      .long_press(a_long), .repeat_pulse(a_rpt), .held(a_held), .rpt_cnt(a_cnt));

   key_event_decoder #(.LONG_TIME(10), .REPEAT_TIME(1), .REPEAT_EN(1'b1), .CNT_W(26)) dut_b (
      .clk(clk), .rst(rst), .key_n(key_b),
      .press_pulse(b_press), .release_pulse(b_rel), .short_click(b_short),
      .long_press(b_long), .repeat_pulse(b_rpt), .held(b_held), .rpt_cnt(b_cnt));

   key_event_decoder #(.LONG_TIME(10), .REPEAT_TIME(4), .REPEAT_EN(1'b0), .CNT_W(26)) dut_c (
      .clk(clk), .rst(rst), .key_n(key_c),
      .press_pulse(c_press), .release_pulse(c_rel), .short_click(c_short),
      .long_press(c_long), .repeat_pulse(c_rpt), .held(c_held), .rpt_cnt(c_cnt));

   function automatic logic [7:0] ev(input bit p, input bit r, input bit s,
                                     input bit l, input bit rp, input bit h);
      return {2'b00, p, r, s, l, rp, h};
   endfunction

   function automatic logic [7:0] obs_a();
      return {2'b00, a_press, a_rel, a_short, a_long, a_rpt, a_held};
   endfunction

   function automatic logic [7:0] obs_b();
      return {2'b00, b_press, b_rel, b_short, b_long, b_rpt, b_held};
   endfunction

   function automatic logic [7:0] obs_c();
      return {2'b00, c_press, c_rel, c_short, c_long, c_rpt, c_held};
   endfunction

   task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      key_a = 1'b1;
      key_b = 1'b1;
      key_c = 1'b1;
      tick();
      tick();
      chk("reset_a", -1, obs_a(), 8'h00);
      chk("reset_cnt", -1, a_cnt, 8'h00);
      rst = 1'b0;
      tick();
      tick();
      chk("idle_a", -1, obs_a(), 8'h00);

      // 1: short click after 5 low edges
      key_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t1_hold", k, obs_a(), ev(k == 0, 0, 0, 0, 0, 1));
      end
      key_a = 1'b1;
      tick();
      chk("t1_release", 5, obs_a(), ev(0, 1, 1, 0, 0, 0));
      tick();
      chk("t1_after", 6, obs_a(), 8'h00);

      // 2: long press with two repeats
      key_a = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t2_hold", k, obs_a(), ev(k == 0, 0, 0, k == 10, (k == 14) || (k == 18), 1));
      end
      chk("t2_cnt", 19, a_cnt, 8'd2);
      key_a = 1'b1;
      tick();
      chk("t2_release", 20, obs_a(), ev(0, 1, 0, 0, 0, 0));
      tick();
      chk("t2_cnt_kept", 21, a_cnt, 8'd2);

      // 3: release sampled on the long threshold edge
      key_a = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_hold", k, obs_a(), ev(k == 0, 0, 0, 0, 0, 1));
      end
      chk("t3_cnt_clr", 9, a_cnt, 8'd0);
      key_a = 1'b1;
      tick();
      chk("t3_release", 10, obs_a(), ev(0, 1, 1, 0, 0, 0));
      tick();
      chk("t3_after", 11, obs_a(), 8'h00);

      // 4: reset while in LONG, key still held
      key_a = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      chk("t4_in_long", 11, obs_a(), ev(0, 0, 0, 0, 0, 1));
      rst = 1'b1;
      #1;
      chk("t4_async", -1, obs_a(), 8'h00);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("t4_held_after_rst", k, obs_a(), 8'h00);
      end
      chk("t4_cnt", 15, a_cnt, 8'd0);
      key_a = 1'b1;
      tick();
      tick();
      chk("t4_idle", -1, obs_a(), 8'h00);
      key_a = 1'b0;
      tick();
      chk("t4_repress", 0, obs_a(), ev(1, 0, 0, 0, 0, 1));
      key_a = 1'b1;
      tick();
      chk("t4_rerelease", 1, obs_a(), ev(0, 1, 1, 0, 0, 0));

      // 5: REPEAT_TIME=1, repeat every edge, count saturates
      key_b = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         chk("t5_hold", k, obs_b(), ev(k == 0, 0, 0, k == 10, k >= 11, 1));
         chk("t5_cnt", k, b_cnt, (k <= 10) ? 8'd0 : ((k - 10 > 255) ? 8'd255 : 8'(k - 10)));
      end
      key_b = 1'b1;
      tick();
      chk("t5_release", 300, obs_b(), ev(0, 1, 0, 0, 0, 0));
      chk("t5_cnt_kept", 300, b_cnt, 8'd255);

      // 6: REPEAT_EN=0, long press only
      key_c = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         chk("t6_hold", k, obs_c(), ev(k == 0, 0, 0, k == 10, 0, 1));
      end
      chk("t6_cnt", 29, c_cnt, 8'd0);
      key_c = 1'b1;
      tick();
      chk("t6_release", 30, obs_c(), ev(0, 1, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
